serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to add a, b, cin; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until next done.
REQ-011 SHALL have port cout  output  1  registered final carry, held with sum.

Function
REQ-012 SHALL compute one bit per cycle, LSB first, through exactly one full_adder instance fed by operand shift-register LSBs and a carry flip-flop.
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally next cycle.
REQ-014 SHALL, on accepted start (cycle T), load a, b into shift registers, cin into carry flop, clear bit counter to 0.
REQ-015 SHALL, each RUN cycle, shift the adder sum bit into the MSB of a partial-sum register, shift operands right by one, load carry flop with adder carry, increment counter.
REQ-016 SHALL leave RUN on the cycle counter equals WIDTH-1; counter width ceil(log2(WIDTH))+1 bits, no wrap inside an operation.
REQ-017 SHALL on DONE entry copy partial sum to sum and carry flop to cout, and assert done for exactly that one cycle (cycle T+WIDTH+1).
REQ-018 SHALL assert busy from cycle T+1 through T+WIDTH inclusive, low otherwise.
REQ-019 SHALL ignore start while in RUN or DONE; captured operands unaffected by a, b, cin changes after T.
REQ-020 SHALL hold sum and cout stable from done until the next done; partial results never visible on sum.
REQ-021 SHALL produce sum = (a + b + cin) mod 2^WIDTH and cout = bit WIDTH of a + b + cin.
REQ-022 SHALL accept a start asserted on the IDLE cycle following DONE (back-to-back throughput WIDTH+2 cycles).

Reset
REQ-023 SHALL on rst high immediately force state IDLE, busy 0, done 0, sum 0, cout 0, counter 0, carry flop 0, shift registers 0.
REQ-024 SHALL abort any in-flight operation on reset with no done pulse; first start after rst deasserts is accepted normally.

Configuration
REQ-025 SHALL, when macro SERIAL_ADDER_OVF_EN is defined, add output ovf (1 bit): signed two's-complement overflow = carry into MSB XOR final carry, registered with sum, reset 0, held with sum.
REQ-026 SHALL, when SERIAL_ADDER_OVF_EN is undefined, have no ovf port and no associated logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-027 SHALL cover: reset, start at T with a=0x3C, b=0x0F, cin=0 -> busy T+1..T+8, done only at T+9, sum=0x4B, cout=0.
REQ-028 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with OVF_EN ovf=0.
REQ-029 SHALL cover: a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0; with OVF_EN ovf=1.
REQ-030 SHALL cover: start pulsed at T+3 of an operation with different a/b -> ignored, result equals first operands, no extra done.
REQ-031 SHALL cover: rst asserted at T+4 mid-RUN -> busy, done, sum, cout 0 immediately; no done; new start after release gives correct result.
REQ-032 SHALL cover: start held high continuously with a=0x01, b=0x01 -> done every 10 cycles, sum=0x02 each time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder, LSB first, WIDTH+2 cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_psum_next;

  full_adder u_fa (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_cout(w_c)
  );

  assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain the shift/carry updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_psum  <= w_psum_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            // Final bit: publish the completed result on the DONE entry edge.
            r_sum   <= w_psum_next;
            r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= r_carry ^ w_c;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a result scoreboard.
// Builds with or without SERIAL_ADDER_OVF_EN; ovf is checked only when defined.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (ea[W-1] == eb[W-1]) && (t[W-1] != ea[W-1]);
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e.sum));
      check({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      last_sum  = e.sum;
      last_cout = e.cout;
    end
  endtask

  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    push_exp(oa, ob, oc);
    a     = oa;
    b     = ob;
    cin   = oc;
    start = 1'b1;
  endtask

  // Full operation with exact busy/done timing; inputs are scrambled after capture.
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc);
    start_op(oa, ob, oc);
    tick();
    start = 1'b0;
    a     = ~oa;
    b     = ~ob;
    cin   = ~oc;
    for (int k = 1; k <= W; k++) begin
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_done_run"}, 32'(done), 32'd0);
      if (k == 4) check({tag, "_sum_held_run"}, 32'(sum), 32'(last_sum));
      tick();
    end
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_result(tag);
    tick();
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(last_sum));
    check({tag, "_cout_hold"}, 32'(cout), 32'(last_cout));
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int last_edge;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    do_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    do_op("add_7f_00_c", 8'h7F, 8'h00, 1'b1);

    // Start re-pulsed with other operands mid-run must be ignored.
    start_op(8'h21, 8'h42, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ign_done_pulse", 32'(done), 32'd1);
    check_result("ign");
    expect_no_done("ign_no_extra_done", 12);

    // Reset in the middle of RUN aborts the operation.
    start_op(8'h12, 8'h34, 1'b1);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    sb.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    expect_no_done("mid_rst_no_done", 12);
    do_op("post_rst", 8'h55, 8'h2A, 1'b1);

    // Start held high: one result every WIDTH+2 cycles.
    for (int i = 0; i < 3; i++) push_exp(8'h01, 8'h01, 1'b0);
    a         = 8'h01;
    b         = 8'h01;
    cin       = 1'b0;
    start     = 1'b1;
    cyc       = 0;
    ndone     = 0;
    last_edge = 0;
    while (ndone < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (done === 1'b1) begin
        ndone++;
        check("b2b_gap", 32'(cyc - last_edge), (ndone == 1) ? 32'd9 : 32'd10);
        last_edge = cyc;
        check_result("b2b");
        if (ndone == 3) start = 1'b0;
      end
    end
    check("b2b_count", 32'(ndone), 32'd3);
    expect_no_done("b2b_drain", 12);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_sum_hold", 32'(sum), 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
